midi_key_source: RTL and testbench



---
 rtl/midi_key_source.sv | 117 +++++++++++
 tb/tb_midi_key_source.sv | 92 +++++++++
 2 files changed

// File: rtl/midi_key_source.sv
// midi_key_source: MIDI byte-stream parser producing one-channel key press/release events
//   clk, rst             : clock, synchronous active-high reset
//   rx_data, rx_valid    : received MIDI byte and its one-cycle strobe
//   key_press            : one-cycle note-on pulse
//   key_release          : one-cycle note-off pulse
//   pitch                : note - NOTE_LO, updated with either pulse
//   freq                 : 24-bit phase increment at 48 kHz, updated with key_press
module midi_key_source #(
   parameter int CHANNEL = 0,
   parameter int NOTE_LO = 24
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        key_press,
   output logic        key_release,
   output logic [5:0]  pitch,
   output logic [23:0] freq
);
   typedef enum logic [1:0] {WAIT_STATUS, DATA1, DATA2} state_t;
   localparam logic [7:0] LO = 8'(NOTE_LO);
   // top octave (notes NOTE_LO+60..+71); lower octaves are right shifts of these
   localparam logic [23:0] TABLE [16] = '{
      24'd365778, 24'd387529, 24'd410573, 24'd434987, 24'd460853, 24'd488256,
      24'd517290, 24'd548049, 24'd580638, 24'd615164, 24'd651744, 24'd690499,
      24'd0, 24'd0, 24'd0, 24'd0};
   state_t      r_state, w_state_nxt;
   logic [7:0]  r_status, w_status_nxt;
   logic [6:0]  r_d1, w_d1_nxt;
   logic        w_done;
   logic [6:0]  w_d1, w_d2;
   logic        w_ch_ok, w_in_range, w_on, w_off, w_evt;
   logic [7:0]  w_rel;
   logic [5:0]  w_p;
   logic [2:0]  w_oct;
   logic [3:0]  w_semi;
   logic        r_s1_press, r_s1_release;
   logic [5:0]  r_s1_pitch;
   logic [3:0]  r_s1_semi;
   logic [2:0]  r_s1_shift;
   always_comb begin
      w_state_nxt  = r_state;
      w_status_nxt = r_status;
      w_d1_nxt     = r_d1;
      w_done       = 1'b0;
      w_d1         = r_d1;
      w_d2         = rx_data[6:0];
      if (rx_valid) begin
         if (rx_data >= 8'hF8) begin
            w_state_nxt = r_state;
         end else if (rx_data >= 8'hF0) begin
            w_state_nxt  = WAIT_STATUS;
            w_status_nxt = 8'h00;
         end else if (rx_data[7]) begin
            w_state_nxt  = DATA1;
            w_status_nxt = rx_data;
         end else if (r_state == DATA1) begin
            w_d1_nxt = rx_data[6:0];
            // program change / channel pressure complete on one data byte
            if (r_status[7:5] == 3'b110) begin
               w_done = 1'b1;
               w_d1   = rx_data[6:0];
            end else begin
               w_state_nxt = DATA2;
            end
         end else if (r_state == DATA2) begin
            w_done      = 1'b1;
            w_state_nxt = DATA1;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= WAIT_STATUS;
         r_status <= 8'h00;
         r_d1     <= 7'd0;
      end else begin
         r_state  <= w_state_nxt;
         r_status <= w_status_nxt;
         r_d1     <= w_d1_nxt;
      end
   end
   assign w_ch_ok    = r_status[3:0] == 4'(CHANNEL);
   assign w_rel      = {1'b0, w_d1} - LO;
   assign w_in_range = ({1'b0, w_d1} >= LO) && (w_rel < 8'd64);
   assign w_p        = w_rel[5:0];
   assign w_on       = (r_status[7:4] == 4'h9) && (w_d2 != 7'd0);
   assign w_off      = (r_status[7:4] == 4'h8) || ((r_status[7:4] == 4'h9) && (w_d2 == 7'd0));
   assign w_evt      = w_done && w_ch_ok && w_in_range;
   assign w_oct      = w_p >= 6'd60 ? 3'd5 : w_p >= 6'd48 ? 3'd4 : w_p >= 6'd36 ? 3'd3 :
                       w_p >= 6'd24 ? 3'd2 : w_p >= 6'd12 ? 3'd1 : 3'd0;
   assign w_semi     = 4'(w_p - 6'(w_oct) * 6'd12);
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_press   <= 1'b0;
         r_s1_release <= 1'b0;
         r_s1_pitch   <= 6'd0;
         r_s1_semi    <= 4'd0;
         r_s1_shift   <= 3'd0;
         key_press    <= 1'b0;
         key_release  <= 1'b0;
         pitch        <= 6'd0;
         freq         <= 24'd0;
      end else begin
         r_s1_press   <= w_evt && w_on;
         r_s1_release <= w_evt && w_off;
         r_s1_pitch   <= w_p;
         r_s1_semi    <= w_semi;
         r_s1_shift   <= 3'd5 - w_oct;
         key_press    <= r_s1_press;
         key_release  <= r_s1_release;
         if (r_s1_press || r_s1_release) pitch <= r_s1_pitch;
         if (r_s1_press) freq <= TABLE[r_s1_semi] >> r_s1_shift;
      end
   end
endmodule

// File: tb/tb_midi_key_source.sv
// tb_midi_key_source: scoreboard bench for midi_key_source
module tb_midi_key_source;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        key_press, key_release;
   logic [5:0]  pitch;
   logic [23:0] freq;
   int nvec = 0, nbad = 0, cyc = 0;
   typedef struct {int k; logic [5:0] p; logic [23:0] f; int due;} exp_t;
   exp_t sb[$];
   midi_key_source #(.CHANNEL(0), .NOTE_LO(24)) dut (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
      .key_press(key_press), .key_release(key_release), .pitch(pitch), .freq(freq));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      nvec++;
      if (a !== e) begin
         nbad++;
         $display("FAIL %s: got %0d expected %0d", n, a, e);
      end
   endtask
   // k: 0 no event, 1 press, 2 release; expected pulse two cycles after this byte
   task automatic send(input logic [7:0] b, input int k = 0, input logic [5:0] p = 0, input logic [23:0] f = 0);
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      if (k != 0) sb.push_back('{k, p, f, cyc + 2});
      @(posedge clk);
      #1 rx_valid = 1'b0;
   endtask
   task automatic chk_zero(input string n);
      chk({n, " press"}, {31'b0, key_press}, 0);
      chk({n, " release"}, {31'b0, key_release}, 0);
      chk({n, " pitch"}, {26'b0, pitch}, 0);
      chk({n, " freq"}, {8'b0, freq}, 0);
   endtask
   always @(negedge clk) begin : monitor
      exp_t e;
      if (key_press || key_release) begin
         chk("exclusive", {31'b0, key_press & key_release}, 0);
         if (sb.size() == 0) begin
            nvec++;
            nbad++;
            $display("FAIL unexpected pulse: press=%0d release=%0d pitch=%0d freq=%0d, none required",
                     key_press, key_release, pitch, freq);
         end else begin
            e = sb.pop_front();
            chk("kind", key_press ? 32'd1 : 32'd2, e.k);
            chk("pitch", {26'b0, pitch}, {26'b0, e.p});
            chk("freq", {8'b0, freq}, {8'b0, e.f});
            chk("latency", cyc, e.due);
         end
      end
   end
   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_zero("reset");
      rst = 1'b0;
      send(8'h90); send(8'h45);
      @(negedge clk) rst = 1'b1;
      repeat (2) @(negedge clk);
      chk_zero("mid-message reset");
      rst = 1'b0;
      send(8'h64);
      send(8'h90); send(8'h45); send(8'h64);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk_zero("squash");
      rst = 1'b0;
      send(8'h90); send(8'h45); send(8'h64, 1, 6'd45, 24'd153791);
      send(8'h80); send(8'h45); send(8'h00, 2, 6'd45, 24'd153791);
      send(8'h90); send(8'h18); send(8'h40, 1, 6'd0, 24'd11430);
      send(8'h18); send(8'h00, 2, 6'd0, 24'd11430);
      send(8'h90); send(8'hF8); send(8'h3C); send(8'hFE); send(8'h7F, 1, 6'd36, 24'd91444);
      send(8'h91); send(8'h3C); send(8'h7F);
      send(8'h90); send(8'h17); send(8'h40);
      send(8'h90); send(8'h58); send(8'h40);
      send(8'h90); send(8'h57); send(8'h40, 1, 6'd63, 24'd434987);
      send(8'hC0); send(8'h05); send(8'h06);
      send(8'h90); send(8'h45); send(8'h64, 1, 6'd45, 24'd153791);
      send(8'h90); send(8'h45); send(8'hF0); send(8'h01); send(8'hF7); send(8'h45); send(8'h64);
      send(8'h90); send(8'h45); send(8'h64, 1, 6'd45, 24'd153791);
      repeat (6) @(negedge clk);
      chk("pending events", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end
endmodule
